dmni_br_receiver: RTL and testbench

- Receive-side endpoint of the BrLite broadcast path into the DMNI; the counterpart of the CPU-driven broadcast transmit registers DMNI_BR_KSVC / DMNI_BR_PAYLOAD.
- Accepts br_payload_t words from the broadcast router with a 4-phase req/ack handshake and buffers them in a small FIFO.
- Exposes the buffered words to the CPU through read-only MMRs at the same offsets, DMNI_BR_KSVC and DMNI_BR_PAYLOAD, and raises an interrupt while data is pending.

---
 rtl/dmni_br_receiver_pkg.sv | 38 +++
 rtl/dmni_br_fifo.sv | 64 ++++++
 rtl/dmni_br_receiver.sv | 106 ++++++++++
 tb/tb_dmni_br_receiver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmni_br_receiver_pkg.sv
// Shared types for the DMNI broadcast receive path: payload word, MMR map and
// handshake FSM encoding, plus the MMR read-data formatter.
`timescale 1ns/1ps
package dmni_br_receiver_pkg;

    typedef struct packed {
        logic [15:0] payload;
        logic [15:0] seq_source;
        logic [3:0]  ksvc;
    } br_payload_t;

    localparam int BR_PAYLOAD_W = $bits(br_payload_t);

    typedef enum logic [7:0] {
        DMNI_BR_KSVC    = 8'h40,
        DMNI_BR_PAYLOAD = 8'h44
    } dmni_mmr_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } br_rx_fsm_t;

    // Formats the head entry for a CPU read; unmapped offsets read as zero.
    function automatic logic [31:0] br_read_word(input logic [7:0] addr,
                                                 input br_payload_t head);
        logic [31:0] word;
        word = '0;
        case (addr)
            DMNI_BR_KSVC:    word = {28'b0, head.ksvc};
            DMNI_BR_PAYLOAD: word = {head.seq_source, head.payload};
            default:         word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/dmni_br_fifo.sv
// Circular-buffer FIFO with an occupancy counter; push is ignored when full and
// pop is ignored when empty. Head entry is presented combinationally.
`timescale 1ns/1ps
module dmni_br_fifo #(
    parameter int BUFFER_SIZE = 4,
    parameter int WIDTH       = 36
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             PTR_W    = $clog2(BUFFER_SIZE);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(BUFFER_SIZE);

    logic [WIDTH-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; entries are only observable once counted
    // valid, so clearing them would add reset fan-out for no behaviour.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmni_br_receiver.sv
// BrLite broadcast receive endpoint: 4-phase req/ack intake into a FIFO,
// drained by the CPU through read-only MMRs, with a pending-data interrupt.
`timescale 1ns/1ps
module dmni_br_receiver
    import dmni_br_receiver_pkg::*;
#(
    parameter int BUFFER_SIZE = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        br_req_i,
    input  logic [35:0] br_payload_i,
    output logic        br_ack_o,
    input  logic        cfg_en_i,
    input  logic        cfg_we_i,
    input  logic [7:0]  cfg_addr_i,
    output logic [31:0] cfg_data_o,
    output logic        irq_o,
    output logic        br_empty_o,
    output logic        br_full_o
);

    br_rx_fsm_t  state_q;
    logic        ack_q;
    logic        irq_q;
    logic [31:0] cfg_data_q;
    logic [31:0] cfg_data_d;

    logic [BR_PAYLOAD_W-1:0] fifo_head;
    br_payload_t             head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    cpu_read;

    assign head     = br_payload_t'(fifo_head);
    assign cpu_read = cfg_en_i && !cfg_we_i;
    assign push     = (state_q == IDLE) && br_req_i && !fifo_full;
    assign pop      = cpu_read && (cfg_addr_i == DMNI_BR_PAYLOAD) && !fifo_empty;

    dmni_br_fifo #(
        .BUFFER_SIZE (BUFFER_SIZE),
        .WIDTH       (BR_PAYLOAD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (br_payload_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: the default hold assignment first keeps this block latch-free.
    always_comb begin
        cfg_data_d = cfg_data_q;
        if (cfg_en_i) begin
            cfg_data_d = '0;
            if (!cfg_we_i && !fifo_empty) begin
                cfg_data_d = br_read_word(cfg_addr_i, head);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            cfg_data_q <= '0;
        end else begin
            irq_q      <= !fifo_empty;
            cfg_data_q <= cfg_data_d;
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!br_req_i) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign br_ack_o   = ack_q;
    assign irq_o      = irq_q;
    assign cfg_data_o = cfg_data_q;
    assign br_empty_o = fifo_empty;
    assign br_full_o  = fifo_full;

endmodule

// File: tb/tb_dmni_br_receiver.sv
// Directed bench for dmni_br_receiver: handshake, back-pressure, simultaneous
// push/pop, illegal MMR access, pointer wrap and mid-handshake reset.
`timescale 1ns/1ps
module tb_dmni_br_receiver;
    import dmni_br_receiver_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        br_req_i;
    logic [35:0] br_payload_i;
    logic        br_ack_o;
    logic        cfg_en_i;
    logic        cfg_we_i;
    logic [7:0]  cfg_addr_i;
    logic [31:0] cfg_data_o;
    logic        irq_o;
    logic        br_empty_o;
    logic        br_full_o;

    int total = 0;
    int bad   = 0;

    dmni_br_receiver #(.BUFFER_SIZE(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .br_req_i     (br_req_i),
        .br_payload_i (br_payload_i),
        .br_ack_o     (br_ack_o),
        .cfg_en_i     (cfg_en_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_o   (cfg_data_o),
        .irq_o        (irq_o),
        .br_empty_o   (br_empty_o),
        .br_full_o    (br_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic br_payload_t mk(input int i);
        br_payload_t w;
        w.payload    = 16'hA000 + 16'(i);
        w.seq_source = 16'h0500 + 16'(i);
        w.ksvc       = 4'(i);
        return w;
    endfunction

    function automatic logic [31:0] exp_pl(input br_payload_t w);
        return {w.seq_source, w.payload};
    endfunction

    // Full 4-phase handshake with bounded waits on both ack edges.
    task automatic send(input br_payload_t w, input string tag);
        int n;
        br_req_i     = 1'b1;
        br_payload_i = w;
        n = 0;
        do begin step(); n++; end while (!br_ack_o && n < 20);
        total++;
        if (br_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL %s ack_rise: ack=%b want 1 after %0d cycles", tag, br_ack_o, n);
            br_req_i = 1'b0;
            return;
        end
        step();
        br_req_i = 1'b0;
        n = 0;
        do begin step(); n++; end while (br_ack_o && n < 5);
        total++;
        if (br_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_fall: ack=%b want 0", tag, br_ack_o);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        cfg_en_i   = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = a;
        step();
        cfg_en_i = 1'b0;
        d = cfg_data_o;
    endtask

    task automatic test_reset();
        total++;
        if ({br_ack_o, irq_o, br_empty_o, br_full_o} !== 4'b0010 || cfg_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset: ack/irq/empty/full=%b data=%h want 0010 data=0",
                     {br_ack_o, irq_o, br_empty_o, br_full_o}, cfg_data_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        br_req_i     = 1'b1;
        br_payload_i = {16'hBEEF, 16'h0102, 4'h3};
        step();
        total++;
        if (br_ack_o !== 1'b1) begin bad++; $display("FAIL single_ack_rise: ack=%b want 1", br_ack_o); end
        step();
        total++;
        if (br_ack_o !== 1'b1 || irq_o !== 1'b1) begin
            bad++; $display("FAIL single_wait_low: ack=%b irq=%b want 1 1", br_ack_o, irq_o);
        end
        br_req_i = 1'b0;
        step();
        total++;
        if (br_ack_o !== 1'b0) begin bad++; $display("FAIL single_ack_fall: ack=%b want 0", br_ack_o); end
        rd(8'h40, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL single_ksvc: got %h want 00000003", d); end
        rd(8'h44, d);
        total++;
        if (d !== 32'h0102BEEF || br_empty_o !== 1'b1 || irq_o !== 1'b1) begin
            bad++; $display("FAIL single_payload: got %h empty=%b irq=%b want 0102beef 1 1", d, br_empty_o, irq_o);
        end
        step();
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL single_irq_fall: irq=%b want 0", irq_o); end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        logic        acc;
        int          n;
        for (int i = 1; i <= 4; i++) send(mk(i), "fill");
        total++;
        if (br_full_o !== 1'b1) begin bad++; $display("FAIL fill_full: full=%b want 1", br_full_o); end
        br_req_i     = 1'b1;
        br_payload_i = mk(5);
        acc = 1'b0;
        repeat (3) begin step(); acc |= br_ack_o; end
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL fill_backpressure: ack seen=%b want 0", acc); end
        rd(8'h44, d);
        total++;
        if (d !== exp_pl(mk(1))) begin bad++; $display("FAIL fill_pop1: got %h want %h", d, exp_pl(mk(1))); end
        n = 0;
        while (!br_ack_o && n < 2) begin step(); n++; end
        total++;
        if (br_ack_o !== 1'b1) begin bad++; $display("FAIL fill_ack5: ack=%b want 1 within 2", br_ack_o); end
        step();
        br_req_i = 1'b0;
        step();
        for (int i = 2; i <= 5; i++) begin
            rd(8'h44, d);
            total++;
            if (d !== exp_pl(mk(i))) begin bad++; $display("FAIL fill_drain%0d: got %h want %h", i, d, exp_pl(mk(i))); end
        end
        total++;
        if (br_empty_o !== 1'b1) begin bad++; $display("FAIL fill_empty: empty=%b want 1", br_empty_o); end
    endtask

    // Push and pop land on one edge; half-full and full variants.
    task automatic test_simultaneous();
        logic [31:0] d;
        send(mk(10), "sim2");
        send(mk(11), "sim2");
        br_req_i = 1'b1; br_payload_i = mk(12);
        cfg_en_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 8'h44;
        step();
        cfg_en_i = 1'b0;
        total++;
        if (cfg_data_o !== exp_pl(mk(10)) || br_ack_o !== 1'b1) begin
            bad++; $display("FAIL sim2_edge: data=%h ack=%b want %h 1", cfg_data_o, br_ack_o, exp_pl(mk(10)));
        end
        step(); br_req_i = 1'b0; step();
        rd(8'h44, d);
        total++;
        if (d !== exp_pl(mk(11)) || br_empty_o !== 1'b0) begin
            bad++; $display("FAIL sim2_second: got %h empty=%b want %h 0", d, br_empty_o, exp_pl(mk(11)));
        end
        rd(8'h44, d);
        total++;
        if (d !== exp_pl(mk(12)) || br_empty_o !== 1'b1) begin
            bad++; $display("FAIL sim2_third: got %h empty=%b want %h 1", d, br_empty_o, exp_pl(mk(12)));
        end

        for (int i = 20; i <= 23; i++) send(mk(i), "simfull");
        br_req_i = 1'b1; br_payload_i = mk(24);
        cfg_en_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 8'h44;
        step();
        cfg_en_i = 1'b0;
        total++;
        if (cfg_data_o !== exp_pl(mk(20)) || br_ack_o !== 1'b0 || br_full_o !== 1'b0) begin
            bad++; $display("FAIL simfull_edge: data=%h ack=%b full=%b want %h 0 0",
                            cfg_data_o, br_ack_o, br_full_o, exp_pl(mk(20)));
        end
        step();
        total++;
        if (br_ack_o !== 1'b1 || br_full_o !== 1'b1) begin
            bad++; $display("FAIL simfull_late_push: ack=%b full=%b want 1 1", br_ack_o, br_full_o);
        end
        step(); br_req_i = 1'b0; step();
        for (int i = 21; i <= 24; i++) begin
            rd(8'h44, d);
            total++;
            if (d !== exp_pl(mk(i))) begin bad++; $display("FAIL simfull_drain%0d: got %h want %h", i, d, exp_pl(mk(i))); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        rd(8'h44, d);
        total++;
        if (d !== 32'h0 || br_empty_o !== 1'b1) begin
            bad++; $display("FAIL empty_read: got %h empty=%b want 0 1", d, br_empty_o);
        end
        send(mk(30), "illegal");
        cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 8'h44;
        step();
        cfg_en_i = 1'b0; cfg_we_i = 1'b0;
        total++;
        if (cfg_data_o !== 32'h0 || br_empty_o !== 1'b0) begin
            bad++; $display("FAIL write_ignored: data=%h empty=%b want 0 0", cfg_data_o, br_empty_o);
        end
        rd(8'h40, d);
        total++;
        if (d !== {28'b0, mk(30).ksvc}) begin bad++; $display("FAIL ksvc_after_write: got %h want %h", d, {28'b0, mk(30).ksvc}); end
        rd(8'h20, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want 0", d); end
        rd(8'h44, d);
        total++;
        if (d !== exp_pl(mk(30))) begin bad++; $display("FAIL illegal_payload: got %h want %h", d, exp_pl(mk(30))); end
        step();
        total++;
        if (cfg_data_o !== exp_pl(mk(30)) || br_empty_o !== 1'b1) begin
            bad++; $display("FAIL data_hold: data=%h empty=%b want %h 1", cfg_data_o, br_empty_o, exp_pl(mk(30)));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        for (int i = 40; i < 50; i++) begin
            send(mk(i), "wrap");
            rd(8'h44, d);
            total++;
            if (d !== exp_pl(mk(i))) begin bad++; $display("FAIL wrap%0d: got %h want %h", i, d, exp_pl(mk(i))); end
        end
        total++;
        if (br_empty_o !== 1'b1) begin bad++; $display("FAIL wrap_empty: empty=%b want 1", br_empty_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          n;
        for (int i = 50; i <= 52; i++) send(mk(i), "rstmid");
        br_req_i = 1'b1; br_payload_i = mk(53);
        n = 0;
        do begin step(); n++; end while (!br_ack_o && n < 20);
        step();
        total++;
        if (br_ack_o !== 1'b1 || br_full_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_wait_low: ack=%b full=%b want 1 1", br_ack_o, br_full_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({br_ack_o, irq_o, br_empty_o, br_full_o} !== 4'b0010) begin
            bad++; $display("FAIL rstmid_async: ack/irq/empty/full=%b want 0010", {br_ack_o, irq_o, br_empty_o, br_full_o});
        end
        br_req_i = 1'b0;
        #3 rst_ni = 1'b1;
        step();
        total++;
        if (br_empty_o !== 1'b1 || br_ack_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_release: empty=%b ack=%b want 1 0", br_empty_o, br_ack_o);
        end
        send(mk(54), "rstmid_new");
        rd(8'h44, d);
        total++;
        if (d !== exp_pl(mk(54)) || br_empty_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_new: got %h empty=%b want %h 1", d, br_empty_o, exp_pl(mk(54)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        br_req_i     = 1'b0;
        br_payload_i = '0;
        cfg_en_i     = 1'b0;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = '0;
        #12;
        test_reset();
        rst_ni = 1'b1;
        step();
        test_single();
        test_fill();
        test_simultaneous();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
